// File: rtl/muldiv_sequencer.sv
// Iterative RV32M execution unit: shift-add multiplier and restoring divider
// sharing one 64-bit accumulator, holding the pipeline with stall while busy.
module muldiv_sequencer #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: an op is accepted on the edge where state is IDLE, start=1 and
  // flush=0; the result is presented for exactly the one cycle valid=1 (FIN).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state, state_nxt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic               s1, s2;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               special;
  logic [WIDTH-1:0]   spec_val;

  logic               signed_a, signed_b, p_s1, p_s2;
  logic [WIDTH-1:0]   p_ma, p_mb;
  logic               div_zero, div_ovf, p_special;
  logic [WIDTH-1:0]   p_spec_val;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quot, rem_s, fin_word;

  assign state_dbg = state;

  // Operand conditioning, evaluated from the latched operands during PREP.
  always_comb begin
    signed_a   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    p_s1       = signed_a & a[WIDTH-1];
    p_s2       = signed_b & b[WIDTH-1];
    p_ma       = p_s1 ? -a : a;
    p_mb       = p_s2 ? -b : b;
    div_zero   = op[2] && (b == '0);
    div_ovf    = op[2] && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    p_special  = div_zero | div_ovf;
    p_spec_val = div_zero ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : MIN_NEG);
  end

  // One iteration of either algorithm plus the sign fix-up of its outcome,
  // so the final result can be registered on the edge that enters FIN.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    if (op[2])
      acc_step = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {sum, acc[WIDTH-1:1]};
    prod  = (s1 ^ s2) ? -acc_step : acc_step;
    quot  = (s1 ^ s2) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_s = s1 ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    case (op)
      3'b000:                 fin_word = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_word = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_word = quot;
      default:                fin_word = rem_s;
    endcase
    if (special) fin_word = spec_val;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = PREP;
      PREP: begin
        if (flush)                          state_nxt = IDLE;
        else if (p_special && FAST_SPECIAL) state_nxt = FIN;
        else                                state_nxt = CALC;
      end
      CALC: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIN drops stall so the pipeline advances while result is valid.
  assign stall = ((state == IDLE) && start && !flush) ||
                 (((state == PREP) || (state == CALC)) && !flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      special  <= 1'b0;
      spec_val <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      valid <= (state_nxt == FIN);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op <= funct3;
            a  <= data1;
            b  <= data2;
          end
        end
        PREP: begin
          s1       <= p_s1;
          s2       <= p_s2;
          ma       <= p_ma;
          mb       <= p_mb;
          acc      <= op[2] ? {{WIDTH{1'b0}}, p_ma} : '0;
          cnt      <= CNT_LAST;
          special  <= p_special;
          spec_val <= p_spec_val;
          if (state_nxt == FIN) result <= p_spec_val;
        end
        CALC: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            if (!op[2]) mb <= mb >> 1;
            if (state_nxt == FIN) result <= fin_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases, flush/reset
// scenarios and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam bit FAST = 1'b1;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] data1, data2;
  logic        stall, busy, valid;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.WIDTH(32), .FAST_SPECIAL(FAST)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .data1(data1), .data2(data2), .flush(flush), .stall(stall),
    .busy(busy), .valid(valid), .result(result), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    logic        ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == MIN_NEG) && (y == ONES);
    case (f)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? ONES : ovf ? MIN_NEG : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? ONES : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'd0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (FAST && f[2] && ((y == 0) || (!f[0] && x == MIN_NEG && y == ONES))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return MIN_NEG;
      2: return ONES;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result %h with nothing expected (cycle %0d)", result, cyc);
      end else begin
        check("result", result, exp_q.pop_front());
        check("valid_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
        check("stall_in_fin", {31'b0, stall}, 32'd0);
      end
    end
  end

  // driver: call at a negedge in IDLE; returns at the negedge after FIN
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int lat, n;
    bit done;
    lat = latency(f, x, y);
    funct3 = f; data1 = x; data2 = y; start = 1'b1;
    exp_q.push_back(ref_op(f, x, y));
    cyc_q.push_back(cyc + lat);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      #1;
      if (stall) n++;
      if (valid) done = 1'b1;
      else begin
        @(negedge clk);
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL op_timeout: no valid for funct3=%0d, expected one at latency %0d", f, lat);
      exp_q.delete();
      cyc_q.delete();
    end
    check("stall_cycles", 32'(n), 32'(lat));
    last_res = ref_op(f, x, y);
    @(negedge clk);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  initial begin
    int i0;
    reset = 1'b1; start = 1'b1; flush = 1'b0;
    funct3 = 3'd0; data1 = 32'd5; data2 = 32'd6;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_valid",  {31'b0, valid}, 32'd0);
    check("reset_result", result,         32'd0);
    check("reset_state",  {30'b0, state_dbg}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, MIN_NEG, MIN_NEG);
    run_op(3'd3, ONES, ONES);
    run_op(3'd2, ONES, ONES);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'h1234_5678, 32'd0);
    run_op(3'd6, 32'h1234_5678, 32'd0);
    run_op(3'd4, 32'h8765_4321, 32'd0);
    run_op(3'd5, 32'h8765_4321, 32'd0);
    run_op(3'd7, 32'h8765_4321, 32'd0);
    run_op(3'd4, MIN_NEG, ONES);
    run_op(3'd6, MIN_NEG, ONES);
    run_op(3'd5, MIN_NEG, ONES);

    // flush a DIVU at cycle 10, restart at cycle 12
    funct3 = 3'd5; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_state", {30'b0, state_dbg}, 32'd0);
    check("flush_result_kept", result, last_res);
    @(negedge clk);
    run_op(3'd5, 32'd1000, 32'd3);

    // back-to-back MUL then DIVU with start held through FIN
    i0 = cyc;
    funct3 = 3'd0; data1 = 32'd7; data2 = 32'hFFFF_FFFD; start = 1'b1;
    exp_q.push_back(ref_op(3'd0, 32'd7, 32'hFFFF_FFFD));
    cyc_q.push_back(i0 + 34);
    exp_q.push_back(ref_op(3'd5, 32'd100, 32'd7));
    cyc_q.push_back(i0 + 69);
    @(negedge clk);
    funct3 = 3'd5; data1 = 32'd100; data2 = 32'd7;
    for (int k = 0; k < 80 && cyc < i0 + 36; k++) @(negedge clk);
    start = 1'b0;
    wait_done();
    last_res = ref_op(3'd5, 32'd100, 32'd7);
    @(negedge clk);

    // reset at cycle 20 of a MUL with start held
    funct3 = 3'd0; data1 = 32'd123; data2 = 32'd456; start = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midop_reset_busy",   {31'b0, busy},  32'd0);
    check("midop_reset_valid",  {31'b0, valid}, 32'd0);
    check("midop_reset_result", result,         32'd0);
    reset = 1'b0;
    start = 1'b0;
    last_res = '0;
    @(negedge clk);

    // random operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
